// File: rtl/dma_region_guard.sv
// DMA access monitor: checks each DMA cycle against up to four protected regions and holds the
// core in reset after a violation. Optional violation log is enabled by defining DMA_GUARD_LOG_EN.
module dma_region_guard #(
  parameter int unsigned NREG          = 4,
  parameter logic [63:0] REG_BASE      = {16'hFFC0, 16'h0000, 16'h0000, 16'h0B00},
  parameter logic [63:0] REG_SIZE      = {16'h001F, 16'h0000, 16'h0000, 16'h0C00},
  parameter logic [3:0]  REG_WO        = 4'b1000,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter logic [7:0]  KILL_CYCLES   = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        dma_we,
  input  logic        log_clr,
  output logic        reset,
  output logic        viol_valid,
  output logic [15:0] viol_addr,
  output logic [1:0]  viol_region,
  output logic [7:0]  viol_count
);

  typedef enum logic [0:0] {StKill, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  viol_vec;
  logic        viol;
  logic [1:0]  first_region;

  // Range checks use widened subtraction so base+size never wraps and no constant compares arise.
  for (genvar i = 0; i < 4; i++) begin : g_region
    localparam logic [15:0] Base   = REG_BASE[16*i +: 16];
    localparam logic [15:0] Size   = REG_SIZE[16*i +: 16];
    localparam logic [16:0] Limit  = {1'b0, Base} + {1'b0, Size};
    localparam bit          Active = (i < int'(NREG)) && (Size != 16'h0000);

    logic [16:0] lo_diff;
    logic [17:0] hi_diff;
    logic        hit;

    assign lo_diff     = {1'b0, dma_addr} - {1'b0, Base};
    assign hi_diff     = {2'b00, dma_addr} - {1'b0, Limit};
    assign hit         = Active && !lo_diff[16] && hi_diff[17];
    assign viol_vec[i] = hit && dma_en && (REG_WO[i] ? dma_we : 1'b1);
  end

  assign viol = |viol_vec;

  always_comb begin
    first_region = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (viol_vec[i]) first_region = 2'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StKill;
      cnt_q   <= KILL_CYCLES;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (viol) begin
          state_d = StKill;
          cnt_d   = KILL_CYCLES;
        end
      end
      StKill: begin
        if (viol) begin
          cnt_d = KILL_CYCLES;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (pc == RESET_HANDLER) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StKill;
        cnt_d   = KILL_CYCLES;
      end
    endcase
  end

  // Output logic: reset mirrors the state register, so there is no combinational path from DMA.
  always_comb begin
    reset = (state_q == StKill);
  end

`ifdef DMA_GUARD_LOG_EN
  logic        log_valid_q, log_valid_d;
  logic [15:0] log_addr_q, log_addr_d;
  logic [1:0]  log_region_q, log_region_d;
  logic [7:0]  log_count_q, log_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid_q  <= 1'b0;
      log_addr_q   <= 16'h0000;
      log_region_q <= 2'd0;
      log_count_q  <= 8'd0;
    end else begin
      log_valid_q  <= log_valid_d;
      log_addr_q   <= log_addr_d;
      log_region_q <= log_region_d;
      log_count_q  <= log_count_d;
    end
  end

  // Clear first, then capture, so a simultaneous clear and violation leaves a fresh entry.
  always_comb begin
    log_valid_d  = log_valid_q;
    log_addr_d   = log_addr_q;
    log_region_d = log_region_q;
    log_count_d  = log_count_q;
    if (log_clr) begin
      log_valid_d  = 1'b0;
      log_addr_d   = 16'h0000;
      log_region_d = 2'd0;
      log_count_d  = 8'd0;
    end
    if (viol) begin
      if (!log_valid_d) begin
        log_valid_d  = 1'b1;
        log_addr_d   = dma_addr;
        log_region_d = first_region;
      end
      if (log_count_d != 8'hFF) log_count_d = log_count_d + 8'd1;
    end
  end

  assign viol_valid  = log_valid_q;
  assign viol_addr   = log_addr_q;
  assign viol_region = log_region_q;
  assign viol_count  = log_count_q;
`else
  logic unused_log;
  assign unused_log  = log_clr ^ (^first_region);

  assign viol_valid  = 1'b0;
  assign viol_addr   = 16'h0000;
  assign viol_region = 2'd0;
  assign viol_count  = 8'd0;
`endif

endmodule
